// File: rtl/derived_tick_averager_if.sv
// Sample-in / window-result bundle between the sample path and derived_tick_averager.
interface derived_tick_averager_if #(
  parameter int DATA_W = 14,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic                     enable;
  logic                     slow_clk_in;
  logic signed [DATA_W-1:0] din;
  logic signed [ACC_W-1:0]  sum_out;
  logic [CNT_W-1:0]         count_out;
  logic signed [DATA_W-1:0] avg_out;
  logic                     out_valid;
  logic                     overflow;
  logic                     busy;

  modport master (
    output enable, slow_clk_in, din,
    input  sum_out, count_out, avg_out, out_valid, overflow, busy
  );

  modport slave (
    input  enable, slow_clk_in, din,
    output sum_out, count_out, avg_out, out_valid, overflow, busy
  );
endinterface

// File: rtl/derived_tick_averager.sv
// Boxcar decimator: sums din over each slow-clock period (edge to edge) and publishes
// sum, sample count and saturated shifted average with a one-cycle valid strobe.
module derived_tick_averager #(
  parameter int DATA_W     = 14,
  parameter int ACC_W      = 32,
  parameter int CNT_W      = 16,
  parameter int AVG_SHIFT  = 4,
  parameter bit BOTH_EDGES = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  derived_tick_averager_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [ACC_W-1:0] AVG_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AVG_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] d);
    return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  // Floor (arithmetic shift), then clamp into the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_avg(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> AVG_SHIFT;
    if (s > AVG_MAX)      s = AVG_MAX;
    else if (s < AVG_MIN) s = AVG_MIN;
    return s[DATA_W-1:0];
  endfunction

  state_t                   r_state;
  logic                     r_slow_q_p0;
  logic signed [ACC_W-1:0]  r_acc_p0;
  logic [CNT_W-1:0]         r_cnt_p0;
  logic                     r_ovf_win_p0;
  logic                     r_busy_p0;
  logic signed [ACC_W-1:0]  r_sum_p1;
  logic [CNT_W-1:0]         r_count_p1;
  logic signed [DATA_W-1:0] r_avg_p1;
  logic                     r_ovf_p1;
  logic                     r_vld_p1;
  logic                     w_tick;

  assign w_tick = BOTH_EDGES ? (bus.slow_clk_in ^ r_slow_q_p0)
                             : (bus.slow_clk_in & ~r_slow_q_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_slow_q_p0  <= 1'b0;
      r_acc_p0     <= '0;
      r_cnt_p0     <= '0;
      r_ovf_win_p0 <= 1'b0;
      r_busy_p0    <= 1'b0;
      r_sum_p1     <= '0;
      r_count_p1   <= '0;
      r_avg_p1     <= '0;
      r_ovf_p1     <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_slow_q_p0 <= bus.slow_clk_in;
      r_vld_p1    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc_p0 <= '0;
          r_cnt_p0 <= '0;
          if (bus.enable && w_tick) begin
            r_state      <= ACCUM;
            r_busy_p0    <= 1'b1;
            r_acc_p0     <= sext(bus.din);
            r_cnt_p0     <= CNT_W'(1);
            r_ovf_win_p0 <= 1'b0;
          end
        end
        ACCUM: begin
          // Abort wins over a coincident tick: the partial window is dropped unpublished.
          if (!bus.enable) begin
            r_state   <= IDLE;
            r_busy_p0 <= 1'b0;
            r_acc_p0  <= '0;
            r_cnt_p0  <= '0;
          end else if (w_tick) begin
            // p0 -> p1: completed window moves to the result registers
            r_sum_p1     <= r_acc_p0;
            r_count_p1   <= r_cnt_p0;
            r_ovf_p1     <= r_ovf_win_p0;
            r_avg_p1     <= sat_avg(r_acc_p0);
            r_vld_p1     <= 1'b1;
            r_acc_p0     <= sext(bus.din);
            r_cnt_p0     <= CNT_W'(1);
            r_ovf_win_p0 <= 1'b0;
          end else if (r_cnt_p0 == CNT_MAX) begin
            r_ovf_win_p0 <= 1'b1;
          end else begin
            r_acc_p0 <= r_acc_p0 + sext(bus.din);
            r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sum_out   = r_sum_p1;
  assign bus.count_out = r_count_p1;
  assign bus.avg_out   = r_avg_p1;
  assign bus.out_valid = r_vld_p1;
  assign bus.overflow  = r_ovf_p1;
  assign bus.busy      = r_busy_p0;

endmodule
